// File: rtl/button_cmd_pkg.sv
// Shared types for the pushbutton command encoder: FSM states, the sel command
// encodings and the press-to-command priority encoder.
package button_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CMD_HOLD  = 2'b00,
        CMD_DEC   = 2'b01,
        CMD_INC   = 2'b10,
        CMD_BLANK = 2'b11
    } cmd_e;

    localparam logic KEY_RELEASED = 1'b1;
    localparam logic KEY_PRESSED  = 1'b0;

    // Simultaneous inc+dec is treated as a blank request.
    function automatic cmd_e encode_cmd(input logic inc, input logic dec, input logic blank);
        cmd_e cmd;
        cmd = CMD_HOLD;
        if (blank || (inc && dec)) begin
            cmd = CMD_BLANK;
        end else if (inc) begin
            cmd = CMD_INC;
        end else if (dec) begin
            cmd = CMD_DEC;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: 2-flop synchronizer, mismatch-count debouncer and
// a registered one-cycle pulse on each debounced released->pressed transition.
module key_debounce
    import button_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mismatch;

    assign mismatch = (sync_q[1] != level_q);

    // NOTE: defaults first so every path assigns every signal; no latch can be inferred.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (mismatch) begin
            // Flip on the DEBOUNCE_CYCLES-th consecutive mismatch; clearing here keeps the counter from wrapping.
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = (sync_q[1] == KEY_PRESSED);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= {2{KEY_RELEASED}};
            level_q <= KEY_RELEASED;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/button_cmd_encoder.sv
// Turns debounced inc/dec/blank presses into a 2-bit command that is offered to
// the downstream state machine for exactly one tick, then re-armed after release.
module button_cmd_encoder
    import button_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_inc,
    input  logic key_dec,
    input  logic key_blank,
    input  logic tick,
    output logic sel1,
    output logic sel0,
    output logic busy
);

    // Bit order for level/press: 0 = inc, 1 = dec, 2 = blank.
    logic [2:0] level;
    logic [2:0] press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_inc),
        .level_o (level[0]),
        .press_o (press[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dec (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_dec),
        .level_o (level[1]),
        .press_o (press[1])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_blank (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_blank),
        .level_o (level[2]),
        .press_o (press[2])
    );

    state_e state_q, state_d;
    cmd_e   cmd_q, cmd_d;
    cmd_e   sel_q, sel_d;
    logic   busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (|press) begin
                    cmd_d   = encode_cmd(press[0], press[1], press[2]);
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (tick) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (&level) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are decoded from next state so the flops below present them with no input-to-output path.
        sel_d  = (state_d == ST_ARMED) ? cmd_d : CMD_HOLD;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_HOLD;
            sel_q   <= CMD_HOLD;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign sel1 = sel_q[1];
    assign sel0 = sel_q[0];
    assign busy = busy_q;

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Self-checking bench for button_cmd_encoder with DEBOUNCE_CYCLES=4: directed
// scenarios plus randomized key/tick/reset traffic against a behavioural model.
module tb_button_cmd_encoder;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst, key_inc, key_dec, key_blank, tick;
    logic sel1, sel0, busy;

    int vecs = 0;
    int errs = 0;

    button_cmd_encoder #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .key_blank (key_blank),
        .tick      (tick),
        .sel1      (sel1),
        .sel0      (sel0),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: a key's debounced level flips once the last DC
    // synchronized samples all disagreed with it; phase 0 waiting, 1 command
    // on offer, 2 waiting for every key to be released.
    bit          m_s0[3], m_s1[3], m_lev[3], m_ev[3];
    bit [DC-1:0] m_win[3];
    int          m_phase;
    bit [1:0]    m_cmd, m_sel;
    bit          m_busy;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_s0[k] = 1'b1; m_s1[k] = 1'b1; m_lev[k] = 1'b1; m_ev[k] = 1'b0; m_win[k] = '0;
        end
        m_phase = 0; m_cmd = 2'b00; m_sel = 2'b00; m_busy = 1'b0;
    endtask

    task automatic model_edge();
        bit          raw[3];
        bit          n_lev[3], n_ev[3];
        bit [DC-1:0] n_win[3];
        raw[0] = key_inc; raw[1] = key_dec; raw[2] = key_blank;
        for (int k = 0; k < 3; k++) begin
            n_win[k] = {m_win[k][DC-2:0], m_s1[k] != m_lev[k]};
            n_lev[k] = m_lev[k];
            n_ev[k]  = 1'b0;
            if (&n_win[k]) begin
                n_lev[k] = !m_lev[k];
                n_ev[k]  = m_lev[k];
                n_win[k] = '0;
            end
        end
        case (m_phase)
            0: if (m_ev[0] || m_ev[1] || m_ev[2]) begin
                   if (m_ev[2] || (m_ev[0] && m_ev[1])) m_cmd = 2'b11;
                   else if (m_ev[0])                    m_cmd = 2'b10;
                   else                                 m_cmd = 2'b01;
                   m_phase = 1;
               end
            1: if (tick) m_phase = 2;
            default: if (m_lev[0] && m_lev[1] && m_lev[2]) m_phase = 0;
        endcase
        m_sel  = (m_phase == 1) ? m_cmd : 2'b00;
        m_busy = (m_phase != 0);
        for (int k = 0; k < 3; k++) begin
            m_s1[k] = m_s0[k]; m_s0[k] = raw[k];
            m_lev[k] = n_lev[k]; m_ev[k] = n_ev[k]; m_win[k] = n_win[k];
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic release_and_wait(input string name);
        key_inc = 1'b1; key_dec = 1'b1; key_blank = 1'b1; tick = 1'b1;
        for (int i = 0; i < 60 && (busy !== 1'b0 || i < DC + 6); i++) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== {m_sel, m_busy}) begin
                errs++; $display("FAIL %s_drain @%0t: sel,busy=%b want %b", name, $time, {sel1, sel0, busy}, {m_sel, m_busy});
            end
        end
        tick = 1'b0;
        vecs++;
        if ({sel1, sel0, busy} !== 3'b000) begin
            errs++; $display("FAIL %s_idle @%0t: sel,busy=%b want 000", name, $time, {sel1, sel0, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_inc = 1'b1; key_dec = 1'b1; key_blank = 1'b1; tick = 1'b0;
        model_reset();
        #1;
        vecs++;
        if ({sel1, sel0, busy} !== 3'b000) begin
            errs++; $display("FAIL reset_async: sel,busy=%b want 000", {sel1, sel0, busy});
        end
        repeat (3) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== 3'b000) begin
                errs++; $display("FAIL reset_hold @%0t: sel,busy=%b want 000", $time, {sel1, sel0, busy});
            end
        end
        rst = 1'b0;
        repeat (4) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== {m_sel, m_busy}) begin
                errs++; $display("FAIL reset_release @%0t: sel,busy=%b want %b", $time, {sel1, sel0, busy}, {m_sel, m_busy});
            end
        end
    endtask

    task automatic test_inc_tick();
        key_inc = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== {m_sel, m_busy}) begin
                errs++; $display("FAIL inc_model @%0t: sel,busy=%b want %b", $time, {sel1, sel0, busy}, {m_sel, m_busy});
            end
            if (i == DC + 2) begin
                vecs++;
                if ({sel1, sel0, busy} !== 3'b000) begin
                    errs++; $display("FAIL inc_early: sel,busy=%b want 000", {sel1, sel0, busy});
                end
            end
            if (i == DC + 3) begin
                vecs++;
                if ({sel1, sel0, busy} !== 3'b101) begin
                    errs++; $display("FAIL inc_latency: sel,busy=%b want 101", {sel1, sel0, busy});
                end
            end
        end
        key_inc = 1'b1;
        repeat (5) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== 3'b101) begin
                errs++; $display("FAIL inc_hold @%0t: sel,busy=%b want 101", $time, {sel1, sel0, busy});
            end
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        vecs++;
        if ({sel1, sel0, busy} !== 3'b001) begin
            errs++; $display("FAIL inc_after_tick: sel,busy=%b want 001", {sel1, sel0, busy});
        end
        release_and_wait("inc");
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 12; i++) begin
            key_dec = (i % 2 == 1);
            step();
            vecs++;
            if ({sel1, sel0, busy} !== 3'b000 || {m_sel, m_busy} !== 3'b000) begin
                errs++; $display("FAIL glitch @%0t: sel,busy=%b model %b want 000", $time, {sel1, sel0, busy}, {m_sel, m_busy});
            end
        end
        key_dec = 1'b1;
        repeat (DC + 4) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== 3'b000) begin
                errs++; $display("FAIL glitch_settle @%0t: sel,busy=%b want 000", $time, {sel1, sel0, busy});
            end
        end
    endtask

    task automatic press_and_deliver(input bit inc, input bit dec, input bit blank,
                                     input bit [1:0] want, input string name);
        key_inc = ~inc; key_dec = ~dec; key_blank = ~blank;
        for (int i = 1; i <= DC + 3; i++) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== {m_sel, m_busy}) begin
                errs++; $display("FAIL %s_model @%0t: sel,busy=%b want %b", name, $time, {sel1, sel0, busy}, {m_sel, m_busy});
            end
        end
        vecs++;
        if ({sel1, sel0, busy} !== {want, 1'b1}) begin
            errs++; $display("FAIL %s_cmd: sel,busy=%b want %b", name, {sel1, sel0, busy}, {want, 1'b1});
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        release_and_wait(name);
    endtask

    task automatic test_simultaneous();
        press_and_deliver(1'b1, 1'b1, 1'b0, 2'b11, "inc_dec");
        press_and_deliver(1'b0, 1'b1, 1'b1, 2'b11, "blank_dec");
        press_and_deliver(1'b0, 1'b1, 1'b0, 2'b01, "dec_only");
    endtask

    task automatic test_armed_ignore();
        key_inc = 1'b0;
        repeat (DC + 3) step();
        vecs++;
        if ({sel1, sel0, busy} !== 3'b101) begin
            errs++; $display("FAIL armed_inc: sel,busy=%b want 101", {sel1, sel0, busy});
        end
        key_dec = 1'b0; key_blank = 1'b0;
        repeat (10) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== 3'b101) begin
                errs++; $display("FAIL armed_ignore @%0t: sel,busy=%b want 101", $time, {sel1, sel0, busy});
            end
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        vecs++;
        if ({sel1, sel0, busy} !== 3'b001) begin
            errs++; $display("FAIL armed_tick: sel,busy=%b want 001", {sel1, sel0, busy});
        end
        release_and_wait("armed");
    endtask

    task automatic test_reset_mid_armed();
        key_dec = 1'b0;
        repeat (DC + 3) step();
        vecs++;
        if ({sel1, sel0, busy} !== 3'b011) begin
            errs++; $display("FAIL rst_armed_dec: sel,busy=%b want 011", {sel1, sel0, busy});
        end
        rst = 1'b1;
        model_reset();
        #1;
        vecs++;
        if ({sel1, sel0, busy} !== 3'b000) begin
            errs++; $display("FAIL rst_armed_async: sel,busy=%b want 000", {sel1, sel0, busy});
        end
        key_dec = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== 3'b000) begin
                errs++; $display("FAIL rst_armed_after @%0t: sel,busy=%b want 000", $time, {sel1, sel0, busy});
            end
        end
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1;
        model_reset();
        key_inc = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 1; i <= DC + 4; i++) begin
            step();
            vecs++;
            if ({sel1, sel0, busy} !== {m_sel, m_busy}) begin
                errs++; $display("FAIL held_model @%0t: sel,busy=%b want %b", $time, {sel1, sel0, busy}, {m_sel, m_busy});
            end
            if (i == DC + 2) begin
                vecs++;
                if ({sel1, sel0} !== 2'b00) begin
                    errs++; $display("FAIL held_early: sel=%b want 00", {sel1, sel0});
                end
            end
            if (i == DC + 3) begin
                vecs++;
                if ({sel1, sel0} !== 2'b10) begin
                    errs++; $display("FAIL held_latency: sel=%b want 10", {sel1, sel0});
                end
            end
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        release_and_wait("held");
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5) == 0) key_inc   = ~key_inc;
            if ($urandom_range(5) == 0) key_dec   = ~key_dec;
            if ($urandom_range(5) == 0) key_blank = ~key_blank;
            tick = ($urandom_range(7) == 0);
            step();
            vecs++;
            if ({sel1, sel0, busy} !== {m_sel, m_busy}) begin
                errs++; $display("FAIL random @%0t: sel,busy=%b want %b", $time, {sel1, sel0, busy}, {m_sel, m_busy});
            end
            if ($urandom_range(599) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                vecs++;
                if ({sel1, sel0, busy} !== 3'b000) begin
                    errs++; $display("FAIL random_rst @%0t: sel,busy=%b want 000", $time, {sel1, sel0, busy});
                end
                step();
                rst = 1'b0;
            end
        end
        release_and_wait("random");
    endtask

    initial begin
        test_reset();
        test_inc_tick();
        test_glitch();
        test_simultaneous();
        test_armed_ignore();
        test_reset_mid_armed();
        test_held_through_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/button_cmd_encoder.md
BUTTON_CMD_ENCODER -- requirements
Module: button_cmd_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles needed before a key's debounced level changes (20 ms at 50 MHz).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_inc  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-005 SHALL have port key_dec  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-006 SHALL have port key_blank  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-007 SHALL have port tick  input  1  one-clk-wide step strobe from the downstream divider; marks the instant the downstream state machine samples sel.
REQ-008 SHALL have port sel1  output  1  command bit 1 to the downstream state machine.
REQ-009 SHALL have port sel0  output  1  command bit 0 to the downstream state machine.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass each key through a 2-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized key independently: a counter clears whenever the synchronized level equals the debounced level, and increments otherwise.
REQ-013 SHALL flip the debounced level in the cycle the counter reaches DEBOUNCE_CYCLES-1 while the mismatch persists; a single-cycle glitch shorter than DEBOUNCE_CYCLES SHALL never flip it.
REQ-014 SHALL size each debounce counter to clog2(DEBOUNCE_CYCLES) bits; the counter SHALL never wrap.
REQ-015 SHALL generate a one-cycle press event when a debounced level goes released(1) to pressed(0); a release generates no event.
REQ-016 SHALL encode {sel1,sel0} as HOLD=00, DEC=01, INC=10, BLANK=11.
REQ-017 SHALL encode press events in one cycle with this priority: blank -> BLANK; inc and dec together -> BLANK; inc only -> INC; dec only -> DEC.
REQ-018 SHALL implement a three-state FSM: IDLE, ARMED, RELEASE.
REQ-019 In IDLE, SHALL drive {sel1,sel0}=HOLD and, on any press event, register the encoded command and go to ARMED; the command SHALL appear on sel one cycle after the event.
REQ-020 In ARMED, SHALL hold the registered command on {sel1,sel0} and ignore all further press events.
REQ-021 In ARMED, on tick=1, SHALL go to RELEASE; {sel1,sel0}=HOLD from the next cycle, so exactly one tick sees each command.
REQ-022 SHALL ignore a tick coinciding with the IDLE->ARMED event cycle; only a tick sampled while in ARMED consumes the command.
REQ-023 In RELEASE, SHALL hold HOLD and go to IDLE in the first cycle all three debounced levels are released; press events in RELEASE SHALL be discarded.
REQ-024 SHALL register all outputs (no combinational path from any input to sel1, sel0 or busy).

Reset
REQ-025 On rst=1, SHALL immediately force sel1=0, sel0=0, busy=0, FSM=IDLE, synchronizers and debounced levels to released(1), and debounce counters to 0.
REQ-026 Reset asserted mid-ARMED SHALL discard the pending command; no command SHALL reach sel after reset release.
REQ-027 A key held through reset release SHALL produce one press event DEBOUNCE_CYCLES+2 cycles later and be processed normally.

Structure
REQ-028 SHALL place the state enum (IDLE, ARMED, RELEASE) and the four command encodings in a shared package, button_cmd_pkg.
REQ-029 SHALL implement synchronizer plus debouncer plus press-edge detection as a sub-module key_debounce, instantiated three times.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 SHALL cover: key_inc held low 10 cycles, then tick pulsed 5 cycles later -> sel=10 from event+1 until the cycle after tick, then 00; busy=1 until key released.
REQ-031 SHALL cover: key_dec toggled 1 low / 1 high for 12 cycles -> no press event, sel stays 00, busy stays 0.
REQ-032 SHALL cover: key_inc and key_dec fall in the same cycle -> sel=11 (BLANK); key_blank with key_dec -> 11.
REQ-033 SHALL cover: second key pressed while ARMED with INC, tick, all keys released -> only INC delivered, then IDLE, sel=00.
REQ-034 SHALL cover: rst pulsed while ARMED with DEC -> sel=00 and busy=0 within the rst cycle; DEC never reappears after rst deasserts.
REQ-035 SHALL cover: key_inc held across rst release -> sel=10 exactly DEBOUNCE_CYCLES+3 cycles after rst deasserts.
